// File: rtl/mailbox_pkg.sv
// ----------------------------------------------------------------------------
// mailbox_pkg : register map, STATUS layout and FSM encoding for the mailbox
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package mailbox_pkg;

   localparam logic [2:0] MBX_DATA    = 3'd0;
   localparam logic [2:0] MBX_STATUS  = 3'd1;
   localparam logic [2:0] MBX_SCRATCH = 3'd2;

   localparam int ST_IN_OVF      = 15;
   localparam int ST_OUT_UNF     = 14;
   localparam int ST_OUT_OVF     = 13;
   localparam int ST_IN_CNT_LSB  = 8;
   localparam int ST_OUT_CNT_LSB = 0;
   localparam int ST_CNT_W       = 5;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_ACK  = 1'b1;

   typedef enum logic [0:0] {
      MBX_IDLE = ST_IDLE,
      MBX_ACK  = ST_ACK
   } mbx_state_e;

   function automatic logic [15:0] mbx_status_word(
      input logic                in_ovf,
      input logic                out_unf,
      input logic                out_ovf,
      input logic [ST_CNT_W-1:0] in_cnt,
      input logic [ST_CNT_W-1:0] out_cnt
   );
      logic [15:0] w;
      w                              = '0;
      w[ST_IN_OVF]                   = in_ovf;
      w[ST_OUT_UNF]                  = out_unf;
      w[ST_OUT_OVF]                  = out_ovf;
      w[ST_IN_CNT_LSB  +: ST_CNT_W]  = in_cnt;
      w[ST_OUT_CNT_LSB +: ST_CNT_W]  = out_cnt;
      return w;
   endfunction

endpackage

`default_nettype wire

// File: rtl/sync_fifo16.sv
// ----------------------------------------------------------------------------
// sync_fifo16 : 16-bit synchronous FIFO, show-ahead head (0 when empty)
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module sync_fifo16 #(
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [15:0]              wdata,
   output logic [15:0]              rdata,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int AW = $clog2(DEPTH);

   logic [15:0] mem_q [DEPTH];
   logic [AW:0] wr_ptr_q, wr_ptr_d;
   logic [AW:0] rd_ptr_q, rd_ptr_d;
   logic        do_push, do_pop;

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   always_comb begin
      empty    = (wr_ptr_q == rd_ptr_q);
      full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
      count    = wr_ptr_q - rd_ptr_q;
      do_pop   = pop && !empty;
      do_push  = push && (!full || do_pop);
      wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
      rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
      rdata    = empty ? 16'h0000 : mem_q[rd_ptr_q[AW-1:0]];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q[AW-1:0]] <= wdata;
      end
   end

endmodule

`default_nettype wire

// File: rtl/avalon_mailbox_slave.sv
// ----------------------------------------------------------------------------
// avalon_mailbox_slave : Avalon-MM <-> MCU 16-bit two-way mailbox; define
// MAILBOX_STALL_EN to stall on full/empty DATA instead of drop + sticky flag.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module avalon_mailbox_slave
   import mailbox_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic        sysclk,
   input  logic        sysreset,
   input  logic [2:0]  avs_address,
   input  logic        avs_read,
   input  logic        avs_write,
   input  logic [15:0] avs_writedata,
   output logic [15:0] avs_readdata,
   output logic        avs_waitrequest,
   output logic [15:0] mcu_rx_data,
   input  logic        mcu_rx_read,
   input  logic [15:0] mcu_tx_data,
   input  logic        mcu_tx_load,
   output logic [15:0] mcu_status,
   output logic        rx_ready,
   output logic        tx_space
);

   localparam int CW = $clog2(DEPTH) + 1;

   mbx_state_e  state_q, state_d;
   logic        wr_q, wr_d;
   logic        rd_hit_q, rd_hit_d;
   logic [2:0]  addr_q, addr_d;
   logic [15:0] wdata_q, wdata_d;
   logic [15:0] rdata_q, rdata_d;
   logic [15:0] scratch_q, scratch_d;
   logic        in_ovf_q, in_ovf_d;
   logic        out_unf_q, out_unf_d;
   logic        out_ovf_q, out_ovf_d;

   logic          in_push, in_full, in_empty;
   logic          out_pop, out_full, out_empty;
   logic [15:0]   in_head, out_head;
   logic [CW-1:0] in_count, out_count;
   logic [15:0]   status, rd_mux;
   logic          req, stall;
   logic          clr_in_ovf, clr_out_unf, clr_out_ovf;
   logic          in_ovf_set, out_unf_set, out_ovf_set;

   sync_fifo16 #(.DEPTH(DEPTH)) u_in_fifo (
      .clk   (sysclk),
      .rst   (sysreset),
      .push  (in_push),
      .pop   (mcu_rx_read),
      .wdata (wdata_q),
      .rdata (in_head),
      .count (in_count),
      .full  (in_full),
      .empty (in_empty)
   );

   sync_fifo16 #(.DEPTH(DEPTH)) u_out_fifo (
      .clk   (sysclk),
      .rst   (sysreset),
      .push  (mcu_tx_load),
      .pop   (out_pop),
      .wdata (mcu_tx_data),
      .rdata (out_head),
      .count (out_count),
      .full  (out_full),
      .empty (out_empty)
   );

   always_comb begin
      status = mbx_status_word(in_ovf_q, out_unf_q, out_ovf_q,
                               ST_CNT_W'(in_count), ST_CNT_W'(out_count));
      req    = avs_read | avs_write;
`ifdef MAILBOX_STALL_EN
      stall  = (avs_address == MBX_DATA) && (avs_write ? in_full : out_empty);
`else
      stall  = 1'b0;
`endif
      case (avs_address)
         MBX_DATA:    rd_mux = out_head;
         MBX_STATUS:  rd_mux = status;
         MBX_SCRATCH: rd_mux = scratch_q;
         default:     rd_mux = 16'h0000;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      wr_d        = wr_q;
      rd_hit_d    = rd_hit_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      rdata_d     = rdata_q;
      scratch_d   = scratch_q;
      in_push     = 1'b0;
      out_pop     = 1'b0;
      clr_in_ovf  = 1'b0;
      clr_out_unf = 1'b0;
      clr_out_ovf = 1'b0;
      in_ovf_set  = 1'b0;
      out_unf_set = 1'b0;

      case (state_q)
         MBX_IDLE: begin
            // Capture the request; a read of an empty DATA is remembered so
            // ACK neither pops nor returns data that arrived meanwhile.
            if (req && !stall) begin
               state_d  = MBX_ACK;
               wr_d     = avs_write;
               addr_d   = avs_address;
               wdata_d  = avs_writedata;
               rd_hit_d = !out_empty;
               rdata_d  = avs_write ? 16'h0000 : rd_mux;
            end
         end
         MBX_ACK: begin
            state_d = MBX_IDLE;
            if (wr_q) begin
               case (addr_q)
                  MBX_DATA: begin
                     in_push    = 1'b1;
                     in_ovf_set = in_full && !mcu_rx_read;
                  end
                  MBX_STATUS: begin
                     clr_in_ovf  = wdata_q[ST_IN_OVF];
                     clr_out_unf = wdata_q[ST_OUT_UNF];
                     clr_out_ovf = wdata_q[ST_OUT_OVF];
                  end
                  MBX_SCRATCH: scratch_d = wdata_q;
                  default: ;
               endcase
            end else if (addr_q == MBX_DATA) begin
               out_pop     = rd_hit_q;
               out_unf_set = !rd_hit_q;
            end
         end
         default: state_d = MBX_IDLE;
      endcase

      out_ovf_set = mcu_tx_load && out_full && !out_pop;
`ifdef MAILBOX_STALL_EN
      in_ovf_set  = 1'b0;
      out_unf_set = 1'b0;
`endif
      in_ovf_d  = in_ovf_set  | (in_ovf_q  & ~clr_in_ovf);
      out_unf_d = out_unf_set | (out_unf_q & ~clr_out_unf);
      out_ovf_d = out_ovf_set | (out_ovf_q & ~clr_out_ovf);
   end

   always_ff @(posedge sysclk or posedge sysreset) begin
      if (sysreset) begin
         state_q   <= MBX_IDLE;
         wr_q      <= 1'b0;
         rd_hit_q  <= 1'b0;
         addr_q    <= 3'd0;
         wdata_q   <= 16'h0000;
         rdata_q   <= 16'h0000;
         scratch_q <= 16'h0000;
         in_ovf_q  <= 1'b0;
         out_unf_q <= 1'b0;
         out_ovf_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         wr_q      <= wr_d;
         rd_hit_q  <= rd_hit_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         rdata_q   <= rdata_d;
         scratch_q <= scratch_d;
         in_ovf_q  <= in_ovf_d;
         out_unf_q <= out_unf_d;
         out_ovf_q <= out_ovf_d;
      end
   end

   assign avs_waitrequest = (state_q == MBX_IDLE) && req;
   assign avs_readdata    = rdata_q;
   assign mcu_rx_data     = in_head;
   assign mcu_status      = status;
   assign rx_ready        = !in_empty;
   assign tx_space        = !out_full;

endmodule

`default_nettype wire

// File: tb/tb_avalon_mailbox_slave.sv
// ----------------------------------------------------------------------------
// tb_avalon_mailbox_slave : scoreboard bench with a queue-based mailbox model
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_avalon_mailbox_slave;

   localparam int DEPTH = 8;
`ifdef MAILBOX_STALL_EN
   localparam bit STALL = 1'b1;
`else
   localparam bit STALL = 1'b0;
`endif

   logic        sysclk        = 1'b0;
   logic        sysreset      = 1'b1;
   logic [2:0]  avs_address   = 3'd0;
   logic        avs_read      = 1'b0;
   logic        avs_write     = 1'b0;
   logic [15:0] avs_writedata = 16'h0000;
   logic [15:0] avs_readdata;
   logic        avs_waitrequest;
   logic [15:0] mcu_rx_data;
   logic        mcu_rx_read   = 1'b0;
   logic [15:0] mcu_tx_data   = 16'h0000;
   logic        mcu_tx_load   = 1'b0;
   logic [15:0] mcu_status;
   logic        rx_ready;
   logic        tx_space;

   int checks = 0;
   int errors = 0;

   logic [15:0] exp_rd_q [$];
   logic [15:0] inq      [$];
   logic [15:0] outq     [$];
   logic        m_in_ovf  = 1'b0;
   logic        m_out_unf = 1'b0;
   logic        m_out_ovf = 1'b0;
   logic [15:0] m_scratch = 16'h0000;

   avalon_mailbox_slave #(.DEPTH(DEPTH)) dut (
      .sysclk          (sysclk),
      .sysreset        (sysreset),
      .avs_address     (avs_address),
      .avs_read        (avs_read),
      .avs_write       (avs_write),
      .avs_writedata   (avs_writedata),
      .avs_readdata    (avs_readdata),
      .avs_waitrequest (avs_waitrequest),
      .mcu_rx_data     (mcu_rx_data),
      .mcu_rx_read     (mcu_rx_read),
      .mcu_tx_data     (mcu_tx_data),
      .mcu_tx_load     (mcu_tx_load),
      .mcu_status      (mcu_status),
      .rx_ready        (rx_ready),
      .tx_space        (tx_space)
   );

   always #5 sysclk = ~sysclk;

   function automatic logic [15:0] model_status();
      return {m_in_ovf, m_out_unf, m_out_ovf, 5'(inq.size()), 3'b000, 5'(outq.size())};
   endfunction

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=0x%04h required=0x%04h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_side();
      chk("rx_ready",    {15'b0, rx_ready}, {15'b0, inq.size() != 0});
      chk("tx_space",    {15'b0, tx_space}, {15'b0, outq.size() < DEPTH});
      chk("mcu_rx_data", mcu_rx_data, (inq.size() != 0) ? inq[0] : 16'h0000);
      chk("mcu_status",  mcu_status, model_status());
   endtask

   task automatic model_reset();
      inq.delete();
      outq.delete();
      m_in_ovf  = 1'b0;
      m_out_unf = 1'b0;
      m_out_ovf = 1'b0;
      m_scratch = 16'h0000;
   endtask

   // One Avalon access; optionally an MCU push lands on the same edge as the ACK.
   task automatic avs_access(input logic wr, input logic rd, input logic [2:0] addr,
                             input logic [15:0] wd, input logic tx, input logic [15:0] txd);
      int          waits;
      logic [15:0] exp;
      logic        had_data;
      had_data = (outq.size() != 0);
      if (rd) begin
         exp = 16'h0000;
         if (!wr) begin
            case (addr)
               3'd0:    exp = had_data ? outq[0] : 16'h0000;
               3'd1:    exp = model_status();
               3'd2:    exp = m_scratch;
               default: exp = 16'h0000;
            endcase
         end
         exp_rd_q.push_back(exp);
      end
      @(posedge sysclk); #1;
      avs_read      = rd;
      avs_write     = wr;
      avs_address   = addr;
      avs_writedata = wd;
      waits = 0;
      while (1) begin
         @(negedge sysclk);
         if (!avs_waitrequest) break;
         waits++;
         if (waits > 100) break;
      end
      chk("wait_cycles", 16'(waits), 16'd1);
      if (tx) begin
         mcu_tx_load = 1'b1;
         mcu_tx_data = txd;
      end
      @(posedge sysclk);
      if (wr) begin
         case (addr)
            3'd0: if (inq.size() < DEPTH) inq.push_back(wd); else m_in_ovf = 1'b1;
            3'd1: begin
               if (wd[15]) m_in_ovf  = 1'b0;
               if (wd[14]) m_out_unf = 1'b0;
               if (wd[13]) m_out_ovf = 1'b0;
            end
            3'd2: m_scratch = wd;
            default: ;
         endcase
      end else if (addr == 3'd0) begin
         if (had_data) void'(outq.pop_front());
         else m_out_unf = 1'b1;
      end
      if (tx) begin
         if (outq.size() < DEPTH) outq.push_back(txd);
         else m_out_ovf = 1'b1;
      end
      #1;
      avs_read    = 1'b0;
      avs_write   = 1'b0;
      mcu_tx_load = 1'b0;
   endtask

   task automatic mcu_push(input logic [15:0] d);
      @(posedge sysclk); #1;
      mcu_tx_load = 1'b1;
      mcu_tx_data = d;
      @(posedge sysclk);
      if (outq.size() < DEPTH) outq.push_back(d);
      else m_out_ovf = 1'b1;
      #1 mcu_tx_load = 1'b0;
   endtask

   task automatic mcu_pop();
      @(posedge sysclk); #1;
      mcu_rx_read = 1'b1;
      @(posedge sysclk);
      if (inq.size() != 0) void'(inq.pop_front());
      #1 mcu_rx_read = 1'b0;
   endtask

   // Monitor: every read completion (ACK cycle) is checked against the scoreboard.
   initial begin
      forever begin
         @(negedge sysclk);
         if (!sysreset && avs_read && !avs_waitrequest) begin
            if (exp_rd_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL readdata_unexpected: actual=0x%04h required=no read pending", avs_readdata);
            end else begin
               chk("readdata", avs_readdata, exp_rd_q.pop_front());
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "bench timeout");
   end

   initial begin
      repeat (3) @(posedge sysclk);
      #1 sysreset = 1'b0;

      // Reset state
      chk("reset_readdata", avs_readdata, 16'h0000);
      chk("reset_waitreq", {15'b0, avs_waitrequest}, 16'h0000);
      check_side();
      avs_access(1'b0, 1'b1, 3'd1, 16'h0, 1'b0, 16'h0);
      avs_access(1'b0, 1'b1, 3'd2, 16'h0, 1'b0, 16'h0);

      // Inbound path
      avs_access(1'b1, 1'b0, 3'd0, 16'h1234, 1'b0, 16'h0);
      avs_access(1'b1, 1'b0, 3'd0, 16'hBEEF, 1'b0, 16'h0);
      check_side();
      mcu_pop();
      check_side();
      mcu_pop();
      check_side();

`ifndef MAILBOX_STALL_EN
      // Inbound overflow, then W1C clear and drain
      for (int i = 0; i < 9; i++) avs_access(1'b1, 1'b0, 3'd0, 16'($urandom), 1'b0, 16'h0);
      check_side();
      avs_access(1'b1, 1'b0, 3'd1, 16'h8000, 1'b0, 16'h0);
      check_side();
      for (int i = 0; i < DEPTH; i++) begin
         mcu_pop();
         check_side();
      end
`endif

      // Outbound path
      mcu_push(16'h00A5);
      check_side();
      avs_access(1'b0, 1'b1, 3'd0, 16'h0, 1'b0, 16'h0);
`ifndef MAILBOX_STALL_EN
      avs_access(1'b0, 1'b1, 3'd0, 16'h0, 1'b0, 16'h0);
      check_side();
      avs_access(1'b1, 1'b0, 3'd1, 16'hE000, 1'b0, 16'h0);
`endif
      check_side();

      // Full outbound: push coinciding with ACK pop, then a true overflow
      for (int i = 0; i < DEPTH; i++) mcu_push(16'($urandom));
      check_side();
      avs_access(1'b0, 1'b1, 3'd0, 16'h0, 1'b1, 16'hC0DE);
      check_side();
      mcu_push(16'h7777);
      check_side();
      for (int i = 0; i < DEPTH; i++) avs_access(1'b0, 1'b1, 3'd0, 16'h0, 1'b0, 16'h0);
      avs_access(1'b1, 1'b0, 3'd1, 16'hE000, 1'b0, 16'h0);
      check_side();

`ifdef MAILBOX_STALL_EN
      // Read on empty outbound stalls until the MCU pushes
      exp_rd_q.push_back(16'h5A5A);
      fork
         begin
            int waits;
            @(posedge sysclk); #1;
            avs_read    = 1'b1;
            avs_address = 3'd0;
            waits = 0;
            while (1) begin
               @(negedge sysclk);
               if (!avs_waitrequest) break;
               waits++;
               if (waits > 100) break;
            end
            chk("stall_wait_cycles", 16'(waits), 16'd21);
            @(posedge sysclk); #1;
            avs_read = 1'b0;
         end
         begin
            @(posedge sysclk); #1;
            repeat (20) @(negedge sysclk);
            mcu_tx_load = 1'b1;
            mcu_tx_data = 16'h5A5A;
            @(posedge sysclk); #1;
            mcu_tx_load = 1'b0;
         end
      join
      check_side();
`endif

      // Randomized traffic
      for (int n = 0; n < 300; n++) begin
         int          op;
         logic [15:0] d;
         op = $urandom_range(0, 9);
         d  = 16'($urandom);
         case (op)
            0, 1: if (!(STALL && inq.size() == DEPTH))
                     avs_access(1'b1, 1'b0, 3'd0, d, 1'b0, 16'h0);
            2, 3: if (!(STALL && outq.size() == 0))
                     avs_access(1'b0, 1'b1, 3'd0, 16'h0, $urandom_range(0, 3) == 0, d);
            4:    avs_access(1'b0, 1'b1, 3'd1, 16'h0, 1'b0, 16'h0);
            5:    avs_access(1'b1, 1'b0, 3'd1, d, 1'b0, 16'h0);
            6:    avs_access(1'b1, 1'b0, 3'd2, d, 1'b0, 16'h0);
            7:    avs_access(1'($urandom_range(0, 1)), 1'b1, 3'($urandom_range(2, 7)), d, 1'b0, 16'h0);
            8:    mcu_push(d);
            default: mcu_pop();
         endcase
         check_side();
      end

      // Reset in the middle of a DATA write: the write must not land
      mcu_push(16'h1111);
      @(posedge sysclk); #1;
      avs_write     = 1'b1;
      avs_address   = 3'd0;
      avs_writedata = 16'hDEAD;
      @(posedge sysclk); #1;
      sysreset  = 1'b1;
      avs_write = 1'b0;
      @(posedge sysclk); #1;
      sysreset = 1'b0;
      model_reset();
      check_side();
      chk("midreset_readdata", avs_readdata, 16'h0000);
      avs_access(1'b0, 1'b1, 3'd2, 16'h0, 1'b0, 16'h0);

      repeat (2) @(posedge sysclk);
      chk("scoreboard_drained", 16'(exp_rd_q.size()), 16'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
